// File: rtl/gpio_apb_arb.sv
// Two-requester round-robin arbiter in front of a single APB master port.
// Registered APB outputs, optional access timeout forcing an error completion.
module gpio_apb_arb #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    req_i,
  input  logic [1:0]    we_i,
  input  logic [2*AW-1:0] addr_i,
  input  logic [2*DW-1:0] wdata_i,
  input  logic [7:0]    strb_i,
  output logic [1:0]    done_o,
  output logic [DW-1:0] rdata_o,
  output logic          err_o,
  output logic          psel_o,
  output logic          penable_o,
  output logic          pwrite_o,
  output logic [AW-1:0] paddr_o,
  output logic [DW-1:0] pwdata_o,
  output logic [3:0]    pstrb_o,
  output logic [2:0]    pprot_o,
  input  logic [DW-1:0] prdata_i,
  input  logic          pready_i,
  input  logic          pslverr_i
);

  typedef enum logic [1:0] {
    IDLE, SETUP, ACCESS, DONE
  } state_t;

  state_t      state, state_d;
  logic        last;
  logic        grant;
  logic        win;
  logic        tmo_hit;
  logic [31:0] tmo_cnt;

  assign pprot_o = 3'b000;

  // Tie goes to whichever requester was not served last.
  assign win = (req_i[0] & req_i[1]) ? ~last : req_i[1];

  assign tmo_hit = (TIMEOUT > 0) &&
                   (tmo_cnt + 32'd1 == 32'(TIMEOUT));

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (|req_i) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (pready_i || tmo_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psel_o    <= 1'b0;
      penable_o <= 1'b0;
      pwrite_o  <= 1'b0;
      paddr_o   <= '0;
      pwdata_o  <= '0;
      pstrb_o   <= '0;
      done_o    <= '0;
      rdata_o   <= '0;
      err_o     <= 1'b0;
      tmo_cnt   <= '0;
      grant     <= 1'b0;
      last      <= 1'b1;
    end else begin
      psel_o    <= (state_d == SETUP) ||
                   (state_d == ACCESS);
      penable_o <= (state_d == ACCESS);
      done_o    <= '0;
      unique case (state)
        IDLE: if (|req_i) begin
          grant    <= win;
          pwrite_o <= we_i[win];
          paddr_o  <= win ? addr_i[2*AW-1:AW]
                          : addr_i[AW-1:0];
          pwdata_o <= win ? wdata_i[2*DW-1:DW]
                          : wdata_i[DW-1:0];
          pstrb_o  <= win ? strb_i[7:4]
                          : strb_i[3:0];
          tmo_cnt  <= '0;
        end
        ACCESS: if (pready_i) begin
          if (!pwrite_o) rdata_o <= prdata_i;
          err_o  <= pslverr_i;
          done_o <= grant ? 2'b10 : 2'b01;
        end else begin
          tmo_cnt <= tmo_cnt + 32'd1;
          if (tmo_hit) begin
            err_o  <= 1'b1;
            done_o <= grant ? 2'b10 : 2'b01;
          end
        end
        DONE:    last <= grant;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_apb_arb.sv
// Directed bench for gpio_apb_arb: read, wait states, contention,
// timeout, slave error and reset during ACCESS.
module tb_gpio_apb_arb;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req_i, we_i;
  logic [2*AW-1:0] addr_i;
  logic [2*DW-1:0] wdata_i;
  logic [7:0]    strb_i;
  logic [1:0]    done_o;
  logic [DW-1:0] rdata_o;
  logic          err_o;
  logic          psel_o, penable_o, pwrite_o;
  logic [AW-1:0] paddr_o;
  logic [DW-1:0] pwdata_o;
  logic [3:0]    pstrb_o;
  logic [2:0]    pprot_o;
  logic [DW-1:0] prdata_i;
  logic          pready_i, pslverr_i;

  int total = 0;
  int bad   = 0;

  gpio_apb_arb #(.AW(AW), .DW(DW), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_i(req_i), .we_i(we_i),
    .addr_i(addr_i), .wdata_i(wdata_i),
    .strb_i(strb_i), .done_o(done_o),
    .rdata_o(rdata_o), .err_o(err_o),
    .psel_o(psel_o), .penable_o(penable_o),
    .pwrite_o(pwrite_o), .paddr_o(paddr_o),
    .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
    .pprot_o(pprot_o), .prdata_i(prdata_i),
    .pready_i(pready_i), .pslverr_i(pslverr_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic wait_done(input int max,
                           output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done_o == 2'b00 && n < max);
    if (done_o == 2'b00) chk("wait_done", 0, 1);
  endtask

  int n, acc;
  logic [1:0] seq [3];
  int gap [3];

  initial begin
    rst_n = 1'b0;
    req_i = '0; we_i = '0;
    addr_i = '0; wdata_i = '0; strb_i = '0;
    prdata_i = '0; pready_i = 1'b0;
    pslverr_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_psel", psel_o, 0);
    chk("rst_pen", penable_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_paddr", paddr_o, 0);
    chk("rst_pwdata", pwdata_o, 0);
    chk("rst_pstrb", pstrb_o, 0);
    chk("rst_pwrite", pwrite_o, 0);
    chk("rst_pprot", pprot_o, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single read, req dropped during SETUP
    req_i = 2'b01; we_i = 2'b00;
    addr_i[31:0] = 32'h10; strb_i = 8'h0F;
    pready_i = 1'b1;
    prdata_i = 32'hA5A5A5A5;
    @(negedge clk);
    chk("rd_setup_psel", psel_o, 1);
    chk("rd_setup_pen", penable_o, 0);
    chk("rd_paddr", paddr_o, 32'h10);
    chk("rd_pwrite", pwrite_o, 0);
    req_i = 2'b00;
    @(negedge clk);
    chk("rd_acc_psel", psel_o, 1);
    chk("rd_acc_pen", penable_o, 1);
    @(negedge clk);
    chk("rd_done", done_o, 2'b01);
    chk("rd_rdata", rdata_o, 32'hA5A5A5A5);
    chk("rd_err", err_o, 0);
    chk("rd_psel_off", psel_o, 0);
    @(negedge clk);
    chk("rd_done_clr", done_o, 0);

    // write with 3 wait states, inputs changed after grant
    req_i = 2'b10; we_i = 2'b10;
    addr_i[63:32] = 32'h04;
    wdata_i[63:32] = 32'h12345678;
    strb_i = 8'hC0;
    pready_i = 1'b0;
    prdata_i = 32'hDEADBEEF;
    @(negedge clk);
    chk("wr_setup_pen", penable_o, 0);
    req_i = 2'b00;
    addr_i[63:32] = 32'hFF;
    wdata_i[63:32] = 32'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("wr_acc_pen", penable_o, 1);
      chk("wr_paddr", paddr_o, 32'h04);
      chk("wr_pwdata", pwdata_o, 32'h12345678);
      chk("wr_pstrb", pstrb_o, 4'hC);
      chk("wr_done_early", done_o, 0);
      if (i == 3) pready_i = 1'b1;
    end
    @(negedge clk);
    chk("wr_done", done_o, 2'b10);
    chk("wr_err", err_o, 0);
    chk("wr_rdata_keep", rdata_o, 32'hA5A5A5A5);

    // contention: both held, grants alternate
    req_i = 2'b11; we_i = 2'b00;
    prdata_i = 32'h0BADCAFE;
    for (int i = 0; i < 3; i++) begin
      wait_done(20, n);
      seq[i] = done_o;
      gap[i] = n;
    end
    req_i = 2'b00;
    chk("arb_0", seq[0], 2'b01);
    chk("arb_1", seq[1], 2'b10);
    chk("arb_2", seq[2], 2'b01);
    chk("arb_gap1", gap[1], 4);
    chk("arb_gap2", gap[2], 4);
    @(negedge clk);

    // timeout
    req_i = 2'b01; pready_i = 1'b0;
    prdata_i = 32'h11111111;
    acc = 0; n = 0;
    do begin
      @(negedge clk);
      n++;
      if (psel_o && penable_o) acc++;
    end while (done_o == 2'b00 && n < 60);
    req_i = 2'b00;
    chk("to_cycles", acc, 16);
    chk("to_done", done_o, 2'b01);
    chk("to_err", err_o, 1);
    chk("to_psel", psel_o, 0);
    chk("to_rdata", rdata_o, 32'h0BADCAFE);
    @(negedge clk);

    // slave error
    req_i = 2'b10; we_i = 2'b10;
    pready_i = 1'b1; pslverr_i = 1'b1;
    wait_done(10, n);
    req_i = 2'b00;
    chk("se_done", done_o, 2'b10);
    chk("se_err", err_o, 1);
    pslverr_i = 1'b0;
    @(negedge clk);

    // reset during ACCESS
    req_i = 2'b01; we_i = 2'b00;
    pready_i = 1'b0;
    prdata_i = 32'h5A5A5A5A;
    repeat (2) @(negedge clk);
    chk("rs_in_acc", penable_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_psel", psel_o, 0);
    chk("rs_pen", penable_o, 0);
    acc = 0;
    repeat (3) begin
      @(negedge clk);
      if (done_o != 2'b00) acc++;
    end
    chk("rs_no_done", acc, 0);
    pready_i = 1'b1;
    rst_n = 1'b1;
    wait_done(10, n);
    req_i = 2'b00;
    chk("rs_resume", done_o, 2'b01);
    chk("rs_rdata", rdata_o, 32'h5A5A5A5A);
    chk("rs_err", err_o, 0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
